// File: rtl/dtc_pkg.sv
// Shared types and default widths for the decision-tree preimage search.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dtc_pkg;

  localparam int DTC_IN_W  = 12;
  localparam int DTC_OUT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } dtc_state_e;

  // A search request: target class plus the first candidate to try.
  typedef struct packed {
    logic [DTC_OUT_W-1:0] cls;
    logic [DTC_IN_W-1:0]  start;
  } dtc_req_t;

  // A search result: count is one wider so a full, fruitless sweep fits.
  typedef struct packed {
    logic                found;
    logic [DTC_IN_W-1:0] inp;
    logic [DTC_IN_W:0]   count;
  } dtc_rsp_t;

endpackage

// File: rtl/dtc_tag_pipe.sv
// Delay line that keeps each issued candidate aligned with its classifier result.
// Latency: LAT cycles from push to out; LAT=0 is a combinational pass-through.
// Backpressure: none; flush drops every in-flight tag on the next edge.
// Ports: clk, rst (sync, active-high), flush, push_valid/push_tag in,
//        out_valid/out_tag (oldest tag), empty (no valid tag anywhere in the line).
module dtc_tag_pipe
  import dtc_pkg::*;
#(
  parameter int LAT = 0,
  parameter int W   = DTC_IN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_valid,
  input  logic [W-1:0] push_tag,
  output logic         out_valid,
  output logic [W-1:0] out_tag,
  output logic         empty
);

  if (LAT == 0) begin : g_pass
    // Nothing is stored, so the line is empty whenever nothing is being pushed.
    logic unused_pass;
    assign unused_pass = ^{clk, rst, flush};
    assign out_valid   = push_valid;
    assign out_tag     = push_tag;
    assign empty       = !push_valid;
  end else begin : g_pipe
    logic [LAT-1:0]        vld;
    logic [LAT-1:0][W-1:0] tag;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        vld <= '0;
      end else begin
        vld[0] <= push_valid;
        for (int i = 1; i < LAT; i++) begin
          vld[i] <= vld[i-1];
        end
      end
    end

    // Tag payload needs no reset; its valid bit alone qualifies it.
    always_ff @(posedge clk) begin
      tag[0] <= push_tag;
      for (int i = 1; i < LAT; i++) begin
        tag[i] <= tag[i-1];
      end
    end

    assign out_valid = vld[LAT-1];
    assign out_tag   = tag[LAT-1];
    assign empty     = ~|vld;
  end

endmodule

// File: rtl/dtc_preimage_search.sv
// Finds the first input (sweeping upward from a start point, wrapping) that a
//   classifier maps to a target class; one candidate issued per cycle.
// Latency: match on candidate k -> rsp_valid k+CLS_LAT+1 cycles after request accept;
//   no match -> 2^IN_W+CLS_LAT+1 cycles. Backpressure: result held until rsp_ready.
// Ports: req_valid/req_ready/req_class/req_start (request), cls_inp/cls_outp
//   (classifier drive/return), rsp_valid/rsp_ready/rsp_found/rsp_inp/rsp_count (result).
module dtc_preimage_search
  import dtc_pkg::*;
#(
  parameter int IN_W    = DTC_IN_W,
  parameter int OUT_W   = DTC_OUT_W,
  parameter int CLS_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_class,
  input  logic [IN_W-1:0]  req_start,
  output logic [IN_W-1:0]  cls_inp,
  input  logic [OUT_W-1:0] cls_outp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_found,
  output logic [IN_W-1:0]  rsp_inp,
  output logic [IN_W:0]    rsp_count
);

  localparam logic [IN_W:0] SPACE = {1'b1, {IN_W{1'b0}}};

  dtc_state_e       state;
  logic [OUT_W-1:0] target_class;
  logic [IN_W-1:0]  start_cand;
  logic [IN_W-1:0]  issued;
  logic [IN_W:0]    count;

  logic             tag_valid;
  logic [IN_W-1:0]  tag;
  logic             pipe_empty;
  logic             comparing;
  logic             hit;
  logic             flush;

  assign req_ready = (state == IDLE);
  assign comparing = (state == SEARCH) || (state == DRAIN);
  assign hit       = comparing && tag_valid && (cls_outp == target_class);
  // Clearing on the hit edge discards every later in-flight candidate, so only
  // the first match can ever reach the response registers.
  assign flush     = hit || (state == IDLE);

  dtc_tag_pipe #(
    .LAT (CLS_LAT),
    .W   (IN_W)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (state == SEARCH),
    .push_tag   (cls_inp),
    .out_valid  (tag_valid),
    .out_tag    (tag),
    .empty      (pipe_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      target_class <= '0;
      start_cand   <= '0;
      issued       <= '0;
      count        <= '0;
      cls_inp      <= '0;
      rsp_valid    <= 1'b0;
      rsp_found    <= 1'b0;
      rsp_inp      <= '0;
      rsp_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            target_class <= req_class;
            start_cand   <= req_start;
            cls_inp      <= req_start;
            issued       <= '0;
            count        <= '0;
            state        <= SEARCH;
          end
        end

        SEARCH, DRAIN: begin
          if (tag_valid) begin
            count <= count + 1'b1;
          end
          if (hit) begin
            rsp_valid <= 1'b1;
            rsp_found <= 1'b1;
            rsp_inp   <= tag;
            rsp_count <= count + 1'b1;
            state     <= RESP;
          end else if (state == SEARCH) begin
            issued <= issued + 1'b1;
            // After the last of 2^IN_W issues cls_inp stays on that candidate.
            if (&issued) begin
              state <= DRAIN;
            end else begin
              cls_inp <= cls_inp + 1'b1;
            end
          end else if (pipe_empty) begin
            rsp_valid <= 1'b1;
            rsp_found <= 1'b0;
            rsp_inp   <= start_cand;
            rsp_count <= SPACE;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_preimage_search.sv
// Directed bench: one search engine per classifier latency (0 and 2), each
// beside a classifier model outp = inp[2:0] (optionally with bit 2 forced set).
module tb_dtc_preimage_search;
  import dtc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 req_valid [2];
  logic                 req_ready [2];
  logic [DTC_OUT_W-1:0] req_class [2];
  logic [DTC_IN_W-1:0]  req_start [2];
  logic [DTC_IN_W-1:0]  cls_inp   [2];
  logic [DTC_OUT_W-1:0] cls_outp  [2];
  logic                 rsp_valid [2];
  logic                 rsp_ready [2];
  logic                 rsp_found [2];
  logic [DTC_IN_W-1:0]  rsp_inp   [2];
  logic [DTC_IN_W:0]    rsp_count [2];
  logic                 no_match  [2];

  int n_cmp = 0;
  int n_bad = 0;

  dtc_preimage_search #(.IN_W(DTC_IN_W), .OUT_W(DTC_OUT_W), .CLS_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_class(req_class[0]), .req_start(req_start[0]),
    .cls_inp(cls_inp[0]), .cls_outp(cls_outp[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_found(rsp_found[0]), .rsp_inp(rsp_inp[0]), .rsp_count(rsp_count[0])
  );

  dtc_preimage_search #(.IN_W(DTC_IN_W), .OUT_W(DTC_OUT_W), .CLS_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_class(req_class[1]), .req_start(req_start[1]),
    .cls_inp(cls_inp[1]), .cls_outp(cls_outp[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_found(rsp_found[1]), .rsp_inp(rsp_inp[1]), .rsp_count(rsp_count[1])
  );

  // Classifier models: combinational for engine 0, two registers deep for engine 1.
  logic [DTC_OUT_W-1:0] m1, m2;
  assign cls_outp[0] = cls_inp[0][2:0] | (no_match[0] ? 3'b100 : 3'b000);
  always @(posedge clk) begin
    m1 <= cls_inp[1][2:0] | (no_match[1] ? 3'b100 : 3'b000);
    m2 <= m1;
  end
  assign cls_outp[1] = m2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure response latency, optionally hold the response
  // under backpressure (pulsing req_valid), then complete the handshake.
  task automatic run_req(input int d, input logic [2:0] cls, input logic [11:0] st,
                         input dtc_rsp_t exp, input int lat, input int hold);
    int cyc;
    @(negedge clk);
    req_class[d] = cls;
    req_start[d] = st;
    req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    chk("busy_after_accept", 32'(req_ready[d]), 32'd0);
    chk("first_candidate", 32'(cls_inp[d]), 32'(st));
    cyc = 0;
    while (!rsp_valid[d] && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rsp_latency", 32'(cyc), 32'(lat));
    chk("rsp_found", 32'(rsp_found[d]), 32'(exp.found));
    chk("rsp_inp", 32'(rsp_inp[d]), 32'(exp.inp));
    chk("rsp_count", 32'(rsp_count[d]), 32'(exp.count));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid[d] = (i % 2 == 0);
      req_class[d] = 3'd3;
      req_start[d] = 12'h000;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_inp", 32'(rsp_inp[d]), 32'(exp.inp));
      chk("hold_count", 32'(rsp_count[d]), 32'(exp.count));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
    chk("req_ready_back", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_class[d] = '0;
      req_start[d] = '0;
      rsp_ready[d] = 1'b0;
      no_match[d]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_cls_inp", 32'(cls_inp[d]), 32'd0);
      chk("reset_rsp_found", 32'(rsp_found[d]), 32'd0);
      chk("reset_rsp_inp", 32'(rsp_inp[d]), 32'd0);
      chk("reset_rsp_count", 32'(rsp_count[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Combinational classifier: plain match, wrap-around match, full sweep miss.
    run_req(0, 3'd5, 12'h000, dtc_rsp_t'{1'b1, 12'h005, 13'd6}, 6, 0);
    chk("lat0_cls_inp_held", 32'(cls_inp[0]), 32'h005);
    run_req(0, 3'd1, 12'hFFE, dtc_rsp_t'{1'b1, 12'h001, 13'd4}, 4, 0);
    no_match[0] = 1'b1;
    run_req(0, 3'd0, 12'h123, dtc_rsp_t'{1'b0, 12'h123, 13'd4096}, 4097, 0);
    chk("lat0_cls_inp_last", 32'(cls_inp[0]), 32'h122);
    no_match[0] = 1'b0;

    // Two-cycle classifier: same data two cycles later; held response under
    // backpressure must not be overwritten by candidates still in flight.
    run_req(1, 3'd5, 12'h000, dtc_rsp_t'{1'b1, 12'h005, 13'd6}, 8, 5);
    chk("lat2_cls_inp_held", 32'(cls_inp[1]), 32'h007);
    repeat (2) @(posedge clk);
    #1;
    chk("pulses_ignored_valid", 32'(rsp_valid[1]), 32'd0);
    chk("pulses_ignored_ready", 32'(req_ready[1]), 32'd1);
    run_req(1, 3'd1, 12'hFFE, dtc_rsp_t'{1'b1, 12'h001, 13'd4}, 6, 0);
    no_match[1] = 1'b1;
    run_req(1, 3'd0, 12'h123, dtc_rsp_t'{1'b0, 12'h123, 13'd4096}, 4099, 0);
    no_match[1] = 1'b0;

    // Reset in the middle of a search aborts it without a response.
    no_match[0] = 1'b1;
    @(negedge clk);
    req_class[0] = 3'd0;
    req_start[0] = 12'h200;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("search_cycle10_cls_inp", 32'(cls_inp[0]), 32'h20A);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
    chk("abort_cls_inp", 32'(cls_inp[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    no_match[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_late_rsp", 32'(rsp_valid[0]), 32'd0);
    // Match on the very first candidate after the abort.
    run_req(0, 3'd2, 12'h0FA, dtc_rsp_t'{1'b1, 12'h0FA, 13'd1}, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
